seg_scan_mux: RTL

Time-multiplexed, parametrised hex seven-segment display driver, the successor to the single-digit combinational decoder with 3-bit anode select. It holds NUM_DIGITS 4-bit values in a shadow register, scans the anodes autonomously from a refresh prescaler, and inserts a blanking gap between digits to avoid ghosting. Per-digit enables and decimal points are supported. It sits between the core logic and the board's 7-seg/anode pins.

---
 rtl/seg_pkg.sv | 21 ++
 rtl/hex7seg_dec.sv | 13 +
 rtl/seg_scan_mux.sv | 126 ++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared types and the hex-to-segment table for the multiplexed 7-segment display driver.
package seg_pkg;

  typedef logic [6:0] seg_t;

  typedef enum logic {SHOW = 1'b0, BLANK = 1'b1} state_t;

  // Active-high gfedcba patterns, indexed by nibble value
  localparam seg_t HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational hex nibble to active-high 7-segment pattern.
module hex7seg_dec
  import seg_pkg::*;
(
  input  logic [3:0] value,
  output seg_t       seg
);

  always_comb begin
    seg = HEX_SEG[value];
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed hex display driver: shadowed digits, autonomous anode scan with
// inter-digit blanking, per-digit enables, selectable output polarity.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   digit_en_i,
  input  logic                    load_i,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   an_o
);

  localparam int unsigned CntW = $clog2(max3(REFRESH_DIV, BLANK_CYCLES, 2));
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CntW-1:0] ShowLast  = CntW'(REFRESH_DIV - 1);
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
  localparam logic [IdxW-1:0] IdxLast   = IdxW'(NUM_DIGITS - 1);

  localparam seg_t                  SegOff = ACTIVE_LOW ? '1 : '0;
  localparam logic                  DpOff  = ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] AnOff  = ACTIVE_LOW ? '1 : '0;

  logic [4*NUM_DIGITS-1:0] shadow_dig_q;
  logic [NUM_DIGITS-1:0]   shadow_dp_q;
  state_t                  state_q, state_d;
  logic [IdxW-1:0]         idx_q, idx_d, idx_next;
  logic [CntW-1:0]         cnt_q, cnt_d;
  seg_t                    seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  logic [3:0]            cur_digit;
  seg_t                  cur_seg;
  logic [NUM_DIGITS-1:0] onehot;

  assign cur_digit = shadow_dig_q[4*idx_q +: 4];

  hex7seg_dec u_dec (
    .value (cur_digit),
    .seg   (cur_seg)
  );

  assign idx_next = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + CntW'(1);
    case (state_q)
      SHOW: begin
        if (cnt_q == ShowLast) begin
          cnt_d = '0;
          if (BLANK_CYCLES > 0) begin
            state_d = BLANK;
          end else begin
            idx_d = idx_next;
          end
        end
      end
      BLANK: begin
        if (cnt_q == BlankLast) begin
          cnt_d   = '0;
          idx_d   = idx_next;
          state_d = SHOW;
        end
      end
      default: begin
        state_d = SHOW;
        cnt_d   = '0;
      end
    endcase
  end

  // Disabled digits still consume their slot so the others keep constant brightness
  always_comb begin
    seg_d  = SegOff;
    dp_d   = DpOff;
    an_d   = AnOff;
    onehot = '0;
    onehot[idx_q] = 1'b1;
    if (state_q == SHOW && digit_en_i[idx_q]) begin
      seg_d = ACTIVE_LOW ? ~cur_seg : cur_seg;
      dp_d  = ACTIVE_LOW ? ~shadow_dp_q[idx_q] : shadow_dp_q[idx_q];
      an_d  = ACTIVE_LOW ? ~onehot : onehot;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_dig_q <= '0;
      shadow_dp_q  <= '0;
      state_q      <= SHOW;
      idx_q        <= '0;
      cnt_q        <= '0;
      seg_q        <= SegOff;
      dp_q         <= DpOff;
      an_q         <= AnOff;
    end else begin
      if (load_i) begin
        shadow_dig_q <= digits_i;
        shadow_dp_q  <= dp_i;
      end
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
    end
  end

  assign seg_o = seg_q;
  assign dp_o  = dp_q;
  assign an_o  = an_q;

endmodule
